// File: rtl/dram_multibank_pkg.sv
// Shared state encoding, default timing constants and derived burst length
// for the multi-bank DRAM timing model.
package dram_multibank_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_CAS,
        S_RD,
        S_WR,
        S_TWR,
        S_CLOSE,
        S_REF_PRE,
        S_REF,
        S_DONE
    } dram_mb_state_t;

    localparam int unsigned DEF_NUM_BANKS  = 4;
    localparam int unsigned DEF_NUM_ROWS   = 16;
    localparam int unsigned DEF_ROW_WIDTH  = 256;
    localparam int unsigned DEF_BEAT_WIDTH = 64;
    localparam int unsigned DEF_TRCD       = 3;
    localparam int unsigned DEF_TCL        = 3;
    localparam int unsigned DEF_TWR        = 2;
    localparam int unsigned DEF_TRP        = 3;
    localparam int unsigned DEF_TREFI      = 200;
    localparam int unsigned DEF_TRFC       = 8;
    localparam int unsigned CNT_W          = 16;

    function automatic int unsigned burst_len(
        input int unsigned row_w,
        input int unsigned beat_w
    );
        return row_w / beat_w;
    endfunction

    localparam int unsigned DEF_BURST_LEN =
        burst_len(DEF_ROW_WIDTH, DEF_BEAT_WIDTH);

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises a sticky pending flag on
// each wrap until the controller clears it.
module dram_refresh_timer
    import dram_multibank_pkg::*;
#(
    parameter int unsigned TREFI_CYCLES = DEF_TREFI
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_pending
);

    localparam int unsigned CW =
        (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(TREFI_CYCLES - 1));

    // A wrap while already pending is simply absorbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap)
                r_pending <= 1'b1;
            else if (i_clear)
                r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/dram_multibank.sv
// Multi-bank DRAM timing model: per-bank open-row tracking, open or
// closed page policy, periodic refresh, one row burst at a time.
module dram_multibank
    import dram_multibank_pkg::*;
#(
    parameter int unsigned NUM_BANKS          = DEF_NUM_BANKS,
    parameter int unsigned NUM_ROWS           = DEF_NUM_ROWS,
    parameter int unsigned ROW_WIDTH          = DEF_ROW_WIDTH,
    parameter int unsigned BURST_ACCESS_WIDTH = DEF_BEAT_WIDTH,
    parameter int unsigned TRCD_CYCLES        = DEF_TRCD,
    parameter int unsigned TCL_CYCLES         = DEF_TCL,
    parameter int unsigned TWR_CYCLES         = DEF_TWR,
    parameter int unsigned TRP_CYCLES         = DEF_TRP,
    parameter int unsigned TREFI_CYCLES       = DEF_TREFI,
    parameter int unsigned TRFC_CYCLES        = DEF_TRFC,
    parameter bit          OPEN_PAGE          = 1'b1,
    localparam int unsigned BW =
        (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned RW =
        (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [BW-1:0]                 req_bank,
    input  logic [RW-1:0]                 req_row,
    input  logic [BURST_ACCESS_WIDTH-1:0] wdata,
    output logic                          wdata_ready,
    output logic [BURST_ACCESS_WIDTH-1:0] rdata,
    output logic                          rdata_valid,
    output logic                          done,
    output logic                          row_hit
);

    localparam int unsigned BURST_LEN =
        burst_len(ROW_WIDTH, BURST_ACCESS_WIDTH);
    localparam int unsigned KW =
        (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned DEPTH = 2 ** (BW + RW + KW);

    dram_mb_state_t r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_load;
    logic [KW-1:0]     r_beat;
    logic              r_run;
    logic              r_write;
    logic [BW-1:0]     r_bank;
    logic [RW-1:0]     r_row;
    logic              r_row_hit;
    logic [NUM_BANKS-1:0] r_open_valid;
    logic [RW-1:0]     r_open_row [NUM_BANKS];
    logic [BURST_ACCESS_WIDTH-1:0] r_mem [DEPTH];

    logic              w_pending;
    logic              w_clear;
    logic              w_tdone;
    logic              w_hit;
    logic              w_ready;
    logic              w_accept;
    logic [BW+RW+KW-1:0] w_addr;

    dram_refresh_timer #(
        .TREFI_CYCLES(TREFI_CYCLES)
    ) u_refresh (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .o_pending(w_pending)
    );

    assign w_tdone  = (r_cnt == '0);
    assign w_hit    = r_open_valid[req_bank] &&
                      (r_open_row[req_bank] == req_row);
    assign w_ready  = r_run && (r_state == S_IDLE) && !w_pending;
    assign w_accept = w_ready && req_valid;
    assign w_clear  = (r_state == S_REF) && w_tdone;
    assign w_addr   = {r_bank, r_row, r_beat};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pending && r_run)
                    w_next = (|r_open_valid) ? S_REF_PRE : S_REF;
                else if (w_accept)
                    w_next = w_hit ? S_CAS :
                             (r_open_valid[req_bank] ? S_PRE : S_ACT);
            end
            S_PRE:     if (w_tdone) w_next = S_ACT;
            S_ACT:     if (w_tdone) w_next = S_CAS;
            S_CAS:     if (w_tdone) w_next = r_write ? S_WR : S_RD;
            S_RD:      if (w_tdone) w_next = OPEN_PAGE ? S_DONE : S_CLOSE;
            S_WR:      if (w_tdone) w_next = S_TWR;
            S_TWR:     if (w_tdone) w_next = OPEN_PAGE ? S_DONE : S_CLOSE;
            S_CLOSE:   if (w_tdone) w_next = S_DONE;
            S_REF_PRE: if (w_tdone) w_next = S_REF;
            S_REF:     if (w_tdone) w_next = S_IDLE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        w_load = '0;
        unique case (w_next)
            S_PRE, S_CLOSE, S_REF_PRE: w_load = CNT_W'(TRP_CYCLES - 1);
            S_ACT:                     w_load = CNT_W'(TRCD_CYCLES - 1);
            S_CAS:                     w_load = CNT_W'(TCL_CYCLES - 1);
            S_RD, S_WR:                w_load = CNT_W'(BURST_LEN - 1);
            S_TWR:                     w_load = CNT_W'(TWR_CYCLES - 1);
            S_REF:                     w_load = CNT_W'(TRFC_CYCLES - 1);
            default:                   w_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_beat       <= '0;
            r_run        <= 1'b0;
            r_write      <= 1'b0;
            r_bank       <= '0;
            r_row        <= '0;
            r_row_hit    <= 1'b0;
            r_open_valid <= '0;
            for (int b = 0; b < NUM_BANKS; b++)
                r_open_row[b] <= '0;
        end else begin
            r_state   <= w_next;
            r_run     <= 1'b1;
            r_row_hit <= w_accept && w_hit;
            // Every timed state loads its length on entry and counts to 0.
            if (w_next != r_state) begin
                r_cnt  <= w_load;
                r_beat <= '0;
            end else begin
                if (!w_tdone)
                    r_cnt <= r_cnt - 1'b1;
                if (r_state == S_RD || r_state == S_WR)
                    r_beat <= r_beat + 1'b1;
            end
            if (w_accept) begin
                r_write <= req_write;
                r_bank  <= req_bank;
                r_row   <= req_row;
            end
            if (w_tdone) begin
                if (r_state == S_PRE || r_state == S_CLOSE)
                    r_open_valid[r_bank] <= 1'b0;
                if (r_state == S_ACT) begin
                    r_open_valid[r_bank] <= 1'b1;
                    r_open_row[r_bank]   <= r_row;
                end
                if (r_state == S_REF_PRE)
                    r_open_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_WR)
            r_mem[w_addr] <= wdata;
    end

    always_comb begin
        req_ready   = w_ready;
        wdata_ready = (r_state == S_WR);
        rdata_valid = (r_state == S_RD);
        rdata       = (r_state == S_RD) ? r_mem[w_addr] : '0;
        done        = (r_state == S_DONE);
        row_hit     = r_row_hit;
    end

endmodule

// File: tb/tb_dram_multibank.sv
// Directed bench: open-page instance for hit/miss/conflict, refresh and
// reset cases; closed-page instance for the precharge-after-access path.
module tb_dram_multibank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0, v1, sel;
    logic        req_write;
    logic [1:0]  req_bank;
    logic [3:0]  req_row;
    logic [63:0] wdata;

    logic        rdy0, wr0, rv0, dn0, hit0;
    logic [63:0] rd0;
    logic        rdy1, wr1, rv1, dn1, hit1;
    logic [63:0] rd1;

    logic        m_ready, m_wready, m_rvalid, m_done, m_hit;
    logic [63:0] m_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dram_multibank dut (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0),
        .req_write(req_write), .req_bank(req_bank),
        .req_row(req_row), .wdata(wdata),
        .wdata_ready(wr0), .rdata(rd0),
        .rdata_valid(rv0), .done(dn0), .row_hit(hit0)
    );

    dram_multibank #(.OPEN_PAGE(1'b0)) dut_cp (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1),
        .req_write(req_write), .req_bank(req_bank),
        .req_row(req_row), .wdata(wdata),
        .wdata_ready(wr1), .rdata(rd1),
        .rdata_valid(rv1), .done(dn1), .row_hit(hit1)
    );

    assign m_ready  = sel ? rdy1 : rdy0;
    assign m_wready = sel ? wr1  : wr0;
    assign m_rvalid = sel ? rv1  : rv0;
    assign m_done   = sel ? dn1  : dn0;
    assign m_hit    = sel ? hit1 : hit0;
    assign m_rdata  = sel ? rd1  : rd0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle n counts from the accepting edge E0 (n=0 is cycle E0).
    task automatic txn(
        input  logic             cp,
        input  logic             wr,
        input  logic [1:0]       bank,
        input  logic [3:0]       row,
        input  logic [3:0][63:0] wb,
        input  int               abort,
        output logic             hit,
        output int               first_rv,
        output int               first_wr,
        output int               done_at,
        output logic [3:0][63:0] rb
    );
        int wcnt, rcnt;
        bit ok;
        wcnt = 0; rcnt = 0; ok = 0; hit = 1'b0;
        first_rv = -1; first_wr = -1; done_at = -1; rb = '0;
        sel = cp; req_write = wr; req_bank = bank; req_row = row;
        if (cp) v1 = 1'b1; else v0 = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (m_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 0) hit = m_hit;
            if (m_rvalid) begin
                if (first_rv < 0) first_rv = n;
                if (rcnt < 4) rb[rcnt] = m_rdata;
                rcnt++;
            end
            if (m_done) begin done_at = n; break; end
            if (abort > 0 && wcnt == abort) begin
                rst = 1'b0;
                break;
            end
            if (m_wready) begin
                if (first_wr < 0) first_wr = n;
                if (wcnt < 4) wdata = wb[wcnt];
                wcnt++;
            end
        end
    endtask

    logic             hit;
    int               frv, fwr, dat, lowc;
    bit               seen;
    logic [3:0][63:0] rb, exp;
    logic [3:0][63:0] none = '0;

    initial begin
        v0 = 1'b0; v1 = 1'b0; sel = 1'b0;
        req_write = 1'b0; req_bank = '0; req_row = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {rdy0, wr0, rv0, dn0, hit0}, 0);
        check("rst_rdata", rd0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", rdy0, 1);

        // Write bank0 row2 into a closed bank, then read it back as a hit.
        exp = {64'h44, 64'h33, 64'h22, 64'h11};
        txn(0, 1, 2'd0, 4'd2, exp, 0, hit, frv, fwr, dat, rb);
        check("w02_hit", hit, 0);
        check("w02_wr", fwr, 6);
        check("w02_done", dat, 12);
        txn(0, 0, 2'd0, 4'd2, none, 0, hit, frv, fwr, dat, rb);
        check("r02_hit", hit, 1);
        check("r02_rv", frv, 3);
        check("r02_done", dat, 7);
        for (int k = 0; k < 4; k++)
            check($sformatf("r02_b%0d", k), rb[k], exp[k]);

        txn(0, 0, 2'd1, 4'd5, none, 0, hit, frv, fwr, dat, rb);
        check("r15_hit", hit, 0);
        check("r15_rv", frv, 6);
        txn(0, 0, 2'd0, 4'd3, none, 0, hit, frv, fwr, dat, rb);
        check("r03_hit", hit, 0);
        check("r03_rv", frv, 9);
        txn(0, 0, 2'd2, 4'd0, none, 0, hit, frv, fwr, dat, rb);
        check("r20_rv", frv, 6);
        txn(0, 0, 2'd0, 4'd3, none, 0, hit, frv, fwr, dat, rb);
        check("r03b_hit", hit, 1);
        check("r03b_rv", frv, 3);

        // Closed page: ACT+CAS+4 beats+TWR+CLOSE, then the row misses again.
        exp = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
        txn(1, 1, 2'd1, 4'd4, exp, 0, hit, frv, fwr, dat, rb);
        check("cp_w_hit", hit, 0);
        check("cp_w_done", dat, 15);
        txn(1, 0, 2'd1, 4'd4, none, 0, hit, frv, fwr, dat, rb);
        check("cp_r_hit", hit, 0);
        check("cp_r_rv", frv, 6);
        check("cp_r_done", dat, 13);
        for (int k = 0; k < 4; k++)
            check($sformatf("cp_b%0d", k), rb[k], exp[k]);

        // Refresh: the IDLE cycle that sees the flag plus TRP+TRFC.
        sel = 1'b0; seen = 0; lowc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!rdy0) begin seen = 1; break; end
        end
        check("ref_seen", seen, 1);
        req_write = 1'b0; req_bank = 2'd0; req_row = 4'd3; v0 = 1'b1;
        while (!rdy0 && lowc < 50) begin
            lowc++;
            @(negedge clk);
        end
        check("ref_busy", lowc, 12);
        txn(0, 0, 2'd0, 4'd3, none, 0, hit, frv, fwr, dat, rb);
        check("ref_r03_hit", hit, 0);
        check("ref_r03_rv", frv, 6);

        // Reset in the middle of a write burst.
        exp = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
        txn(0, 1, 2'd3, 4'd7, exp, 0, hit, frv, fwr, dat, rb);
        check("w37_done", dat, 12);
        exp = {64'hB4, 64'hB3, 64'hB2, 64'hB1};
        txn(0, 1, 2'd3, 4'd7, exp, 2, hit, frv, fwr, dat, rb);
        check("wb37_hit", hit, 1);
        check("wb37_wr", fwr, 3);
        #1;
        check("mid_rst_ctl", {rdy0, wr0, rv0, dn0, hit0}, 0);
        check("mid_rst_rdata", rd0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rdy_after_rst2", rdy0, 1);
        exp = {64'hA4, 64'hA3, 64'hB2, 64'hB1};
        txn(0, 0, 2'd3, 4'd7, none, 0, hit, frv, fwr, dat, rb);
        check("r37_hit", hit, 0);
        check("r37_rv", frv, 6);
        for (int k = 0; k < 4; k++)
            check($sformatf("r37_b%0d", k), rb[k], exp[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
